seg_scan: RTL

- Time-multiplexed scan driver for the board's 8-digit hex display.
- Holds a 32-bit display word, for example the CPU debug/register value.
- Steps through enabled digits at a fixed rate and presents one 4-bit digit code `d` plus digit select `an` per step. `d` feeds the downstream digit pass-through stage.
- The display word is double-buffered so an update never tears mid-frame.

---
 rtl/seg_scan_pkg.sv | 21 ++
 rtl/seg_scan_tick.sv | 37 +++
 rtl/seg_scan.sv | 119 +++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared constants and types for the 8-digit hex scan display driver.
//   N_DIGITS : number of display digits
//   DIGIT_W  : bits per hex digit code
//   SEL_W    : width of the digit select index
//   DATA_W   : width of the full display word (N_DIGITS * DIGIT_W)
// -----------------------------------------------------------------------------
package seg_scan_pkg;

   localparam int N_DIGITS = 8;
   localparam int DIGIT_W  = 4;
   localparam int SEL_W    = 3;
   localparam int DATA_W   = N_DIGITS * DIGIT_W;

   typedef logic [DIGIT_W-1:0]  digit_t;
   typedef logic [SEL_W-1:0]    sel_t;
   typedef logic [DATA_W-1:0]   word_t;
   typedef logic [N_DIGITS-1:0] mask_t;

endpackage : seg_scan_pkg

// File: rtl/seg_scan_tick.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Free-running prescaler producing a one-cycle tick every DIV clock cycles.
// Shared by the periodic board-I/O blocks (display scan, key debounce, ...).
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the count
//   tick : high in the cycle the count equals DIV-1 (every cycle when DIV = 1)
// -----------------------------------------------------------------------------
module scan_tick_gen #(
   parameter int DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   // A one-bit counter is kept for DIV = 1 so the register is never zero-width;
   // it simply sits at 0 and the compare below is always true.
   localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_r;

   // Prescaler count: 0..DIV-1, wrapping to 0 after the tick cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == LAST) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign tick = (cnt_r == LAST);

endmodule : scan_tick_gen

// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan
// Time-multiplexed scan driver for the 8-digit hex display. A 32-bit word is
// staged by `load` and committed to the displayed (shadow) copy only at a frame
// boundary, so a frame never shows a mix of old and new digits.
//   clk        : system clock
//   rst        : synchronous active-high reset (abandons frame, drops pending load)
//   data_in    : new display word, digit i = data_in[4i+3:4i]
//   load       : single-cycle strobe, stage data_in (last load in a frame wins)
//   en_mask    : bit i enables digit i in the scan
//   an         : selected digit index (registered)
//   d          : hex code of selected digit (registered)
//   valid      : an/d show an enabled digit (registered)
//   frame_done : one-cycle pulse after each frame boundary (registered)
// -----------------------------------------------------------------------------
module seg_scan
   import seg_scan_pkg::*;
#(
   parameter int SCAN_DIV = 100000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]   data_in,
   input  logic               load,
   input  logic [N_DIGITS-1:0] en_mask,
   output logic [SEL_W-1:0]    an,
   output logic [DIGIT_W-1:0]  d,
   output logic               valid,
   output logic               frame_done
);

   // Next enabled digit after cur, searching cur+1, cur+2, ... and ending with
   // cur itself. The loop runs from the farthest offset down so the nearest
   // enabled digit is the last assignment. With an empty mask cur is returned.
   function automatic sel_t next_digit(input sel_t cur, input mask_t mask);
      sel_t res;
      sel_t idx;
      res = cur;
      for (int k = N_DIGITS; k >= 1; k--) begin
         idx = cur + SEL_W'(k);
         if (mask[idx]) begin
            res = idx;
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   logic  tick_s;
   sel_t  nxt_s;
   logic  boundary_s;

   sel_t  ptr_r;
   word_t shadow_r;
   word_t staged_r;
   logic  pending_r;

   scan_tick_gen #(
      .DIV (SCAN_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_s)
   );

   // Step target and frame-boundary detect: a boundary is a step that does not
   // move the pointer forward (wrap, or a lone enabled digit re-selecting itself).
   always_comb begin
      nxt_s      = next_digit(ptr_r, en_mask);
      boundary_s = 1'b0;
      if (tick_s && (en_mask != {N_DIGITS{1'b0}}) && (nxt_s <= ptr_r)) begin
         boundary_s = 1'b1;
      end else begin
         boundary_s = 1'b0;
      end
   end

   // Scan pointer and double-buffered display word. A load in the boundary
   // cycle leaves pending set, so it commits at the following boundary while
   // this boundary commits the previously staged value.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r     <= {SEL_W{1'b0}};
         shadow_r  <= {DATA_W{1'b0}};
         staged_r  <= {DATA_W{1'b0}};
         pending_r <= 1'b0;
      end else begin
         if (tick_s) begin
            ptr_r <= nxt_s;
         end
         if (boundary_s && pending_r) begin
            shadow_r <= staged_r;
         end
         if (load) begin
            staged_r  <= data_in;
            pending_r <= 1'b1;
         end else if (boundary_s) begin
            pending_r <= 1'b0;
         end
      end
   end

   // Output register, one cycle behind pointer/shadow.
   always_ff @(posedge clk) begin
      if (rst) begin
         an         <= {SEL_W{1'b0}};
         d          <= {DIGIT_W{1'b0}};
         valid      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         an         <= ptr_r;
         d          <= shadow_r[DIGIT_W*ptr_r +: DIGIT_W];
         valid      <= en_mask[ptr_r];
         frame_done <= boundary_s;
      end
   end

endmodule : seg_scan
